// File: rtl/spi_slave.sv
// spi_slave: SPI slave for modes 0-3, oversampled in the clk domain, with a reloadable tx buffer
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       busy,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS,
    output logic       MISO
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, ss_q;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   cpol_l, cpha_l;
    logic [7:0]             tx_buf, tx_sr, rx_sr, tx_next;
    logic [2:0]             bit_cnt;
    logic                   ss_fall, ss_rise, start, abort, act, sclk_chg;
    logic                   lead, trail, last, sample, shift_ev, reload;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign ss_s   = ss_q[SYNC_STAGES-1];
    assign busy   = state == ACTIVE;
    assign MISO   = busy & tx_sr[7];

    // bring the master's pins into clk and keep one-cycle-old copies for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q <= '0;
            mosi_q <= '0;
            ss_q   <= '0;
            sclk_d <= 1'b0;
            ss_d   <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], SS};
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
        end
    end

    // decode select/clock events and choose the next transfer state
    always_comb begin
        ss_fall  = ss_d & ~ss_s;
        ss_rise  = ~ss_d & ss_s;
        start    = (state == IDLE) & ss_fall;
        abort    = (state == ACTIVE) & ss_rise;
        act      = (state == ACTIVE) & ~ss_s;
        sclk_chg = sclk_s ^ sclk_d;
        lead     = act & sclk_chg & (sclk_d == cpol_l);
        trail    = act & sclk_chg & (sclk_s == cpol_l);
        last     = bit_cnt == 3'd7;
        sample   = cpha_l ? trail : lead;
        shift_ev = (cpha_l ? lead : trail) & (bit_cnt != 3'd0);
        reload   = cpha_l ? (sample & last) : (trail & (bit_cnt == 3'd0));
        tx_next  = tx_load ? tx_data : tx_buf;
        state_nx = (state == IDLE) ? (ss_fall ? ACTIVE : IDLE) : (ss_rise ? IDLE : ACTIVE);
    end

    // transfer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // freeze the SPI mode for the whole select window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpol_l <= 1'b0;
            cpha_l <= 1'b0;
        end else if (start) begin
            cpol_l <= cpol;
            cpha_l <= cpha;
        end
    end

    // tx buffer is sticky so an unreloaded buffer repeats its byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       tx_buf <= 8'h00;
        else if (tx_load) tx_buf <= tx_data;
    end

    // tx shift register: load at select, reload on byte boundaries, shift on the driving edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 tx_sr <= 8'h00;
        else if (start || reload)   tx_sr <= tx_next;
        else if (!abort && shift_ev) tx_sr <= {tx_sr[6:0], 1'b0};
    end

    // rx shift register and bit counter; partial bytes are discarded on deselect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sr   <= 8'h00;
            bit_cnt <= 3'd0;
            rx_data <= 8'h00;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || abort) begin
                rx_sr   <= 8'h00;
                bit_cnt <= 3'd0;
            end else if (sample) begin
                rx_sr   <= {rx_sr[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (last) begin
                    rx_data <= {rx_sr[6:0], mosi_s};
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master against a cycle-level behavioural model of the slave
module tb_spi_slave;
    localparam int S = 2;

    typedef struct {
        int         c;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0, reset = 1'b0, cpol = 1'b0, cpha = 1'b0, tx_load = 1'b0;
    logic       SCLK = 1'b0, MOSI = 1'b0, SS = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       done, busy, MISO;

    int         checks = 0, passed = 0, cyc = 0, done_cnt = 0;
    bit         ssh [S+2];
    logic       exp_busy = 1'b0;
    logic [7:0] exp_rx = 8'h00, model_buf = 8'h00;
    ev_t        dq[$];
    logic [7:0] mo [4], ldv [4], got [4];
    bit         lde [4];
    int         ldb [4];

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
        .done(done), .busy(busy), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    // per-cycle model: busy follows SS delayed by the synchronizer, done/rx_data follow scheduled byte completions
    always @(posedge clk) begin
        logic ed;
        #1;
        cyc++;
        ed = 1'b0;
        for (int k = S + 1; k > 0; k--) ssh[k] = ssh[k-1];
        ssh[0] = SS;
        if (!reset) begin
            foreach (ssh[k]) ssh[k] = 1'b0;
            exp_busy = 1'b0;
            exp_rx = 8'h00;
            dq.delete();
        end else begin
            if (ssh[S+1] && !ssh[S]) exp_busy = 1'b1;
            else if (!ssh[S+1] && ssh[S]) exp_busy = 1'b0;
            if (dq.size() > 0 && dq[0].c == cyc) begin
                ed = 1'b1;
                exp_rx = dq[0].b;
                void'(dq.pop_front());
            end
        end
        if (done === 1'b1) done_cnt++;
        chk("done", 8'(done), 8'(ed));
        chk("rx_data", rx_data, exp_rx);
        chk("busy", 8'(busy), 8'(exp_busy));
        if (!exp_busy) chk("miso_idle", 8'(MISO), 8'h00);
    end

    task automatic hw(input int h);
        repeat (h) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        model_buf = v;
    endtask

    // master side of one byte (or nb bits); optional tx_load after the leading edge of bit ld_bit
    task automatic spi_byte(input logic [7:0] mb, input int nb, input int h, input bit ld,
                            input int ld_bit, input logic [7:0] ld_v, output logic [7:0] sb);
        sb = 8'h00;
        for (int i = 0; i < nb; i++) begin
            if (!cpha) MOSI = mb[7-i];
            hw(h);
            SCLK = ~cpol;
            if (cpha) MOSI = mb[7-i];
            else begin
                sb = {sb[6:0], MISO};
                if (i == 7) dq.push_back('{c: cyc + 1 + S, b: mb});
            end
            if (ld && i == ld_bit) begin
                load(ld_v);
                hw(h - 1);
            end else hw(h);
            SCLK = cpol;
            if (cpha) begin
                sb = {sb[6:0], MISO};
                if (i == 7) dq.push_back('{c: cyc + 1 + S, b: mb});
            end
        end
    endtask

    task automatic xfer(input logic cp, input logic ch, input int n, input int h, input int nbits);
        logic [7:0] e;
        cpol = cp;
        cpha = ch;
        SCLK = cp;
        hw(4);
        SS = 1'b0;
        hw(h);
        for (int k = 0; k < n; k++) begin
            e = model_buf;
            spi_byte(mo[k], nbits, h, lde[k], ldb[k], ldv[k], got[k]);
            if (nbits == 8) chk("miso_byte", got[k], e);
        end
        hw(h);
        SS = 1'b1;
        hw(8);
    endtask

    initial begin
        int d0;
        foreach (lde[k]) lde[k] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        hw(4);
        chk("reset_rx", rx_data, 8'h00);
        chk("reset_busy", 8'(busy), 8'h00);

        // mode 0 single byte
        load(8'hA5);
        mo[0] = 8'h3C;
        d0 = done_cnt;
        xfer(1'b0, 1'b0, 1, 50, 8);
        chk("m0_rx", rx_data, 8'h3C);
        chk("m0_miso", got[0], 8'hA5);
        chk("m0_done_cnt", 8'(done_cnt - d0), 8'd1);

        // modes 1, 2, 3
        for (int m = 1; m < 4; m++) begin
            load(8'h81);
            mo[0] = 8'h7E;
            xfer(m[1], m[0], 1, 20, 8);
            chk("mode_rx", rx_data, 8'h7E);
            chk("mode_miso", got[0], 8'h81);
        end

        // two bytes under one select, new tx byte loaded between them
        load(8'h55);
        mo[0] = 8'h12;
        mo[1] = 8'h34;
        lde[0] = 1'b1;
        ldb[0] = 7;
        ldv[0] = 8'hAA;
        d0 = done_cnt;
        xfer(1'b0, 1'b0, 2, 50, 8);
        lde[0] = 1'b0;
        chk("b2b_miso0", got[0], 8'h55);
        chk("b2b_miso1", got[1], 8'hAA);
        chk("b2b_rx", rx_data, 8'h34);
        chk("b2b_done_cnt", 8'(done_cnt - d0), 8'd2);

        // abort after five SCLK cycles, then a full byte
        mo[0] = 8'hF0;
        d0 = done_cnt;
        xfer(1'b0, 1'b0, 1, 10, 5);
        chk("abort_busy", 8'(busy), 8'h00);
        chk("abort_rx", rx_data, 8'h34);
        chk("abort_done_cnt", 8'(done_cnt - d0), 8'd0);
        load(8'h96);
        mo[0] = 8'h69;
        xfer(1'b0, 1'b0, 1, 10, 8);
        chk("post_abort_rx", rx_data, 8'h69);
        chk("post_abort_miso", got[0], 8'h96);

        // reset pulsed mid-byte
        cpol = 1'b0;
        cpha = 1'b0;
        SCLK = 1'b0;
        hw(4);
        SS = 1'b0;
        hw(10);
        spi_byte(8'hE7, 3, 10, 1'b0, 0, 8'h00, got[0]);
        d0 = done_cnt;
        reset = 1'b0;
        model_buf = 8'h00;
        hw(2);
        chk("rst_rx", rx_data, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_miso", 8'(MISO), 8'h00);
        reset = 1'b1;
        hw(10);
        chk("rst_no_restart", 8'(busy), 8'h00);
        SS = 1'b1;
        hw(8);
        chk("rst_done_cnt", 8'(done_cnt - d0), 8'd0);
        mo[0] = 8'hC3;
        xfer(1'b0, 1'b0, 1, 10, 8);
        chk("post_rst_rx", rx_data, 8'hC3);
        chk("post_rst_miso", got[0], 8'h00);

        // randomized transfers: mode, length, rate, data and tx reload points
        for (int t = 0; t < 15; t++) begin
            int n;
            n = $urandom_range(3, 1);
            if ($urandom_range(1, 0) == 1) load(8'($urandom));
            for (int k = 0; k < n; k++) begin
                mo[k] = 8'($urandom);
                lde[k] = $urandom_range(1, 0) == 1;
                ldb[k] = $urandom_range(7, 0);
                ldv[k] = 8'($urandom);
            end
            xfer($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, n, $urandom_range(10, 4), 8);
            chk("rand_rx", rx_data, mo[n-1]);
        end

        hw(4);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
